// File: rtl/ask_frame_sync_if.sv
// Bit-stream input and byte-stream output bundle of the ASK frame synchroniser.
// The master drives the demodulated bits; the slave returns bytes and lock status.
interface ask_frame_sync_if;
    logic       en;
    logic       bit_in;
    logic       bit_valid;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_start;
    logic       frame_done;
    logic       locked;
    logic [7:0] sync_err_cnt;

    modport master (
        output en, bit_in, bit_valid,
        input  byte_out, byte_valid, frame_start,
        input  frame_done, locked, sync_err_cnt
    );

    modport slave (
        input  en, bit_in, bit_valid,
        output byte_out, byte_valid, frame_start,
        output frame_done, locked, sync_err_cnt
    );
endinterface

// File: rtl/ask_frame_sync.sv
// Sync-word hunter and payload byte assembler behind the ASK demodulator.
// Flywheel verify tolerates a few bit errors and drops lock after repeated misses.
module ask_frame_sync #(
    parameter int unsigned SYNC_W        = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA5,
    parameter int unsigned PAYLOAD_BYTES = 4,
    parameter int unsigned SYNC_TOL      = 1,
    parameter int unsigned LOSS_LIM      = 2
) (
    input logic             clk,
    input logic             rst_n,
    ask_frame_sync_if.slave bus
);

    localparam int unsigned CNT_W  = $clog2((SYNC_W > 8) ? SYNC_W : 8);
    localparam int unsigned HAM_W  = $clog2(SYNC_W + 1);
    localparam int unsigned MISS_W = (LOSS_LIM > 1) ? $clog2(LOSS_LIM) : 1;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        VERIFY  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SYNC_W-1:0] sr_q, sr_d, sr_new;
    logic [7:0]        byte_sr_q, byte_sr_d, byte_new;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]        byte_cnt_q, byte_cnt_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [7:0]        byte_out_q, byte_out_d;
    logic              byte_valid_q, byte_valid_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_done_q, frame_done_d;
    logic              locked_q, locked_d;
    logic [7:0]        err_q, err_d;
    logic [HAM_W-1:0]  ham;
    logic              take;

    function automatic logic [HAM_W-1:0] popcount(input logic [SYNC_W-1:0] v);
        logic [HAM_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(SYNC_W); i++) begin
            n = n + HAM_W'(v[i]);
        end
        return n;
    endfunction

    assign take     = bus.en && bus.bit_valid;
    assign sr_new   = {sr_q[SYNC_W-2:0], bus.bit_in};
    assign byte_new = {byte_sr_q[6:0], bus.bit_in};
    assign ham      = popcount(sr_new ^ SYNC_WORD);

    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        byte_sr_d     = byte_sr_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        miss_d        = miss_q;
        byte_out_d    = byte_out_q;
        locked_d      = locked_q;
        err_d         = err_q;
        byte_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        if (take) begin
            unique case (state_q)
                HUNT: begin
                    sr_d = sr_new;
                    if (sr_new == SYNC_WORD) begin
                        state_d       = PAYLOAD;
                        sr_d          = '0;
                        locked_d      = 1'b1;
                        frame_start_d = 1'b1;
                        bit_cnt_d     = '0;
                        byte_cnt_d    = '0;
                        miss_d        = '0;
                    end
                end
                PAYLOAD: begin
                    byte_sr_d = byte_new;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(7)) begin
                        bit_cnt_d    = '0;
                        byte_out_d   = byte_new;
                        byte_valid_d = 1'b1;
                        byte_cnt_d   = byte_cnt_q + 8'd1;
                        if (byte_cnt_q == 8'(PAYLOAD_BYTES - 1)) begin
                            frame_done_d = 1'b1;
                            state_d      = VERIFY;
                            sr_d         = '0;
                            byte_cnt_d   = '0;
                        end
                    end
                end
                VERIFY: begin
                    sr_d      = sr_new;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(SYNC_W - 1)) begin
                        bit_cnt_d = '0;
                        if (ham <= HAM_W'(SYNC_TOL)) begin
                            miss_d        = '0;
                            frame_start_d = 1'b1;
                            state_d       = PAYLOAD;
                        end else begin
                            if (err_q != 8'hFF) begin
                                err_d = err_q + 8'd1;
                            end
                            // last allowed miss: give up and hunt from a clean register
                            if (miss_q == MISS_W'(LOSS_LIM - 1)) begin
                                miss_d   = '0;
                                locked_d = 1'b0;
                                state_d  = HUNT;
                                sr_d     = '0;
                            end else begin
                                miss_d        = miss_q + 1'b1;
                                frame_start_d = 1'b1;
                                state_d       = PAYLOAD;
                            end
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            sr_q          <= '0;
            byte_sr_q     <= '0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            miss_q        <= '0;
            byte_out_q    <= '0;
            byte_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            byte_sr_q     <= byte_sr_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            miss_q        <= miss_d;
            byte_out_q    <= byte_out_d;
            byte_valid_q  <= byte_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
        end
    end

    assign bus.byte_out     = byte_out_q;
    assign bus.byte_valid   = byte_valid_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.locked       = locked_q;
    assign bus.sync_err_cnt = err_q;

endmodule
